// File: rtl/hex_load_ctrl_if.sv
// Avalon-MM slave bus of the hex load controller.
// The Nios side uses the master modport and the controller uses the slave modport.
interface hex_load_ctrl_if;
    logic [1:0] avs_address;
    logic       avs_read;
    logic       avs_write;
    logic [7:0] avs_writedata;
    logic [7:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/hex_load_ctrl.sv
// Two-digit hex display controller: debounced manual nibble loads, arbitrated
// against Avalon-MM register writes, with a level interrupt for software.
module hex_load_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       sw_in,
    input  logic             load_key_n,
    hex_load_ctrl_if.slave   avs,
    output logic             irq,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } db_state_e;

    typedef enum logic [1:0] {
        ADDR_DIGITS = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_CTRL   = 2'd2,
        ADDR_RSVD   = 2'd3
    } addr_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]       SEG_ZERO = 7'b1000000;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Synchronizer chains
    logic [3:0] sw_meta_q, sw_sync_q;
    logic       key_meta_q, key_sync_q;

    // Debounce FSM
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_pulse;

    // Register file and outputs
    logic [3:0] digit0_q, digit0_d;
    logic [3:0] digit1_q, digit1_d;
    logic       ptr_q, ptr_d;
    logic       new_data_q, new_data_d;
    logic       irq_en_q, irq_en_d;
    logic       lock_q, lock_d;
    logic       pending_q, pending_d;
    logic [3:0] pend_nib_q, pend_nib_d;
    logic [7:0] rdata_q, rdata_d;
    logic       irq_q;
    logic [6:0] hex0_q, hex1_q;

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            // Key chain resets to "released" so a key held through reset
            // still needs a full fresh debounce.
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
        end else begin
            sw_meta_q  <= sw_in;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= load_key_n;
            key_sync_q <= key_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_pulse = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!key_sync_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_sync_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = ST_HELD;
                    load_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (key_sync_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!key_sync_q) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    logic       digits_wr, status_wr, ctrl_wr;
    logic       manual_req, set_nd, clr_nd;
    logic [3:0] manual_nib;

    always_comb begin
        digit0_d   = digit0_q;
        digit1_d   = digit1_q;
        ptr_d      = ptr_q;
        irq_en_d   = irq_en_q;
        lock_d     = lock_q;
        pending_d  = 1'b0;
        pend_nib_d = pend_nib_q;
        rdata_d    = rdata_q;
        set_nd     = 1'b0;

        digits_wr = avs.avs_write && (addr_e'(avs.avs_address) == ADDR_DIGITS);
        status_wr = avs.avs_write && (addr_e'(avs.avs_address) == ADDR_STATUS);
        ctrl_wr   = avs.avs_write && (addr_e'(avs.avs_address) == ADDR_CTRL);
        clr_nd    = status_wr && avs.avs_writedata[0];

        // A deferred load was already accepted, so lock no longer gates it.
        manual_req = pending_q || (load_pulse && !lock_q);
        manual_nib = pending_q ? pend_nib_q : sw_sync_q;

        if (digits_wr) begin
            digit0_d = avs.avs_writedata[3:0];
            digit1_d = avs.avs_writedata[7:4];
            ptr_d    = 1'b0;
            if (manual_req) begin
                pending_d  = 1'b1;
                pend_nib_d = manual_nib;
            end
        end else if (manual_req) begin
            if (ptr_q) digit1_d = manual_nib;
            else       digit0_d = manual_nib;
            ptr_d  = ~ptr_q;
            set_nd = 1'b1;
        end

        if (ctrl_wr) begin
            irq_en_d = avs.avs_writedata[0];
            lock_d   = avs.avs_writedata[1];
        end

        new_data_d = set_nd || (new_data_q && !clr_nd);

        // Reads use current register values, so a same-cycle write is not seen.
        if (avs.avs_read) begin
            unique case (addr_e'(avs.avs_address))
                ADDR_DIGITS: rdata_d = {digit1_q, digit0_q};
                ADDR_STATUS: rdata_d = {5'b0, lock_q, ptr_q, new_data_q};
                ADDR_CTRL:   rdata_d = {6'b0, lock_q, irq_en_q};
                ADDR_RSVD:   rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digit0_q   <= '0;
            digit1_q   <= '0;
            ptr_q      <= 1'b0;
            new_data_q <= 1'b0;
            irq_en_q   <= 1'b0;
            lock_q     <= 1'b0;
            pending_q  <= 1'b0;
            pend_nib_q <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            hex0_q     <= SEG_ZERO;
            hex1_q     <= SEG_ZERO;
        end else begin
            digit0_q   <= digit0_d;
            digit1_q   <= digit1_d;
            ptr_q      <= ptr_d;
            new_data_q <= new_data_d;
            irq_en_q   <= irq_en_d;
            lock_q     <= lock_d;
            pending_q  <= pending_d;
            pend_nib_q <= pend_nib_d;
            rdata_q    <= rdata_d;
            irq_q      <= new_data_q && irq_en_q;
            hex0_q     <= seg7(digit0_q);
            hex1_q     <= seg7(digit1_q);
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign irq              = irq_q;
    assign hex0             = hex0_q;
    assign hex1             = hex1_q;

endmodule

// File: tb/tb_hex_load_ctrl.sv
// Scoreboard bench for hex_load_ctrl: stimulus queues expected read data and
// output probes, a monitor compares them when the DUT presents each value.
module tb_hex_load_ctrl;

    typedef struct {
        string      name;
        int         kind;   // 0 readdata, 1 hex0, 2 hex1, 3 irq
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sw_in;
    logic       load_key_n;
    logic       irq;
    logic [6:0] hex0, hex1;

    int total = 0;
    int bad   = 0;

    exp_t rd_q[$];
    exp_t pr_q[$];
    logic rd_flag   = 1'b0;
    logic probe_req = 1'b0;

    hex_load_ctrl_if bus ();

    hex_load_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_in      (sw_in),
        .load_key_n (load_key_n),
        .avs        (bus),
        .irq        (irq),
        .hex0       (hex0),
        .hex1       (hex1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: read data is valid in the cycle after a sampled avs_read.
    always @(posedge clk) rd_flag <= bus.avs_read;

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] act;
        if (rd_flag) begin
            if (rd_q.size() == 0) check("rd_unexpected", bus.avs_readdata, 8'hxx);
            else begin
                e = rd_q.pop_front();
                check(e.name, bus.avs_readdata, e.val);
            end
        end
        if (probe_req) begin
            if (pr_q.size() == 0) check("probe_unexpected", 8'h00, 8'hxx);
            else begin
                e = pr_q.pop_front();
                case (e.kind)
                    1:       act = {1'b0, hex0};
                    2:       act = {1'b0, hex1};
                    3:       act = {7'b0, irq};
                    default: act = bus.avs_readdata;
                endcase
                check(e.name, act, e.val);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        idle(1);
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
        rd_q.push_back('{name, 0, exp});
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        idle(1);
        bus.avs_read    = 1'b0;
    endtask

    task automatic rw(input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp,
                      input string name);
        rd_q.push_back('{name, 0, exp});
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        idle(1);
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
    endtask

    task automatic probe(input int kind, input logic [7:0] exp, input string name);
        pr_q.push_back('{name, kind, exp});
        probe_req = 1'b1;
        idle(1);
        probe_req = 1'b0;
    endtask

    task automatic press(input logic [3:0] sw);
        sw_in      = sw;
        load_key_n = 1'b0;
        idle(12);
        load_key_n = 1'b1;
        idle(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n           = 1'b0;
        sw_in             = 4'h5;
        load_key_n        = 1'b0;
        bus.avs_address   = 2'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        // Key held through reset, released as reset ends: no load may occur.
        reset_n    = 1'b1;
        load_key_n = 1'b1;
        probe(1, 8'h40, "rst_hex0");
        probe(2, 8'h40, "rst_hex1");
        probe(3, 8'h00, "rst_irq");
        probe(0, 8'h00, "rst_readdata");
        idle(20);
        rd(2'd0, 8'h00, "rst_digits");
        rd(2'd1, 8'h00, "rst_status");
        rd(2'd2, 8'h00, "rst_ctrl");

        // Clean presses
        press(4'h5);
        rd(2'd0, 8'h05, "press1_digits");
        rd(2'd1, 8'h03, "press1_status");
        probe(1, 8'h12, "press1_hex0");
        press(4'hA);
        rd(2'd0, 8'hA5, "press2_digits");
        rd(2'd1, 8'h01, "press2_status");
        probe(2, 8'h08, "press2_hex1");

        // Bounce, then long hold: a single load into digit0
        wr(2'd1, 8'h01);
        sw_in      = 4'h3;
        load_key_n = 1'b0;
        idle(2);
        load_key_n = 1'b1;
        idle(1);
        load_key_n = 1'b0;
        idle(50);
        rd(2'd0, 8'hA3, "bounce_digits");
        load_key_n = 1'b1;
        idle(12);
        rd(2'd1, 8'h03, "bounce_status");

        // Collision: DIGITS write in the load-pulse cycle
        wr(2'd1, 8'h01);
        sw_in      = 4'h7;
        load_key_n = 1'b0;
        idle(6);
        wr(2'd0, 8'h3C);
        rd(2'd0, 8'h3C, "coll_cpu_first");
        rd(2'd0, 8'h37, "coll_digits");
        rd(2'd1, 8'h03, "coll_status");
        probe(1, 8'h78, "coll_hex0");
        load_key_n = 1'b1;
        idle(12);

        // IRQ: one-cycle lag behind new_data
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h01);
        sw_in      = 4'hE;
        load_key_n = 1'b0;
        idle(7);
        probe(3, 8'h00, "irq_lag");
        probe(3, 8'h01, "irq_set");
        load_key_n = 1'b1;
        idle(12);
        wr(2'd1, 8'h01);
        idle(1);
        probe(3, 8'h00, "irq_cleared");
        // Clear coinciding with a load: set wins
        sw_in      = 4'h9;
        load_key_n = 1'b0;
        idle(6);
        wr(2'd1, 8'h01);
        idle(2);
        probe(3, 8'h01, "irq_set_wins");
        rd(2'd1, 8'h03, "setwins_status");
        load_key_n = 1'b1;
        idle(12);
        rd(2'd0, 8'hE9, "irq_digits");
        probe(1, 8'h10, "hex0_9");
        probe(2, 8'h06, "hex1_E");

        // Lock: presses ignored
        wr(2'd2, 8'h02);
        rd(2'd2, 8'h02, "lock_ctrl");
        wr(2'd1, 8'h01);
        press(4'h1);
        rd(2'd0, 8'hE9, "lock_digits");
        rd(2'd1, 8'h06, "lock_status");
        probe(3, 8'h00, "lock_irq");

        // Read and write same cycle, reserved address, readdata hold
        rw(2'd2, 8'h00, 8'h02, "rw_prewrite");
        rd(2'd2, 8'h00, "rw_postwrite");
        wr(2'd3, 8'hFF);
        rd(2'd3, 8'h00, "rsvd_read");
        idle(3);
        probe(0, 8'h00, "readdata_hold");
        rd(2'd0, 8'hE9, "final_digits");
        idle(3);

        check("rd_q_drained", 8'(rd_q.size()), 8'd0);
        check("pr_q_drained", 8'(pr_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
